// File: rtl/keypad_pkg.sv
// Shared types and constants for the 8x4 keypad row-scan controller.
package keypad_pkg;

    localparam int unsigned KEY_W = 5;
    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 4;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EVAL
    } state_t;

    // Frame candidate: valid=0 means no key pressed in the frame.
    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] code;
    } cand_t;

    localparam cand_t NO_KEY = '{valid: 1'b0, code: '0};

    // Index of the lowest asserted column line; 0 if none.
    function automatic logic [COL_W-1:0] first_col(input logic [COLS-1:0] c);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (c[COLS-1-i]) begin
                idx = COL_W'(COLS - 1 - i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_row_timer.sv
// Dwell and row counters: steps row_sel 0..7, SETTLE cycles per row.
// Row stays at 7 after the last dwell cycle until clr restarts the frame.
module kp_row_timer
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             adv,
    output logic [ROW_W-1:0] row_sel,
    output logic             sample_strobe,
    output logic             frame_end
);

    localparam int unsigned DW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [DW-1:0] LAST_DWELL = DW'(SETTLE - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [DW-1:0]    dwell;
    logic [ROW_W-1:0] row;

    assign row_sel       = row;
    assign sample_strobe = adv && (dwell == LAST_DWELL);
    assign frame_end     = sample_strobe && (row == LAST_ROW);

    // Advance dwell counter; step row at the end of each dwell period.
    always_ff @(posedge clk) begin
        if (!nrst || clr) begin
            dwell <= '0;
            row   <= '0;
        end else if (adv) begin
            if (dwell == LAST_DWELL) begin
                dwell <= '0;
                if (row != LAST_ROW) begin
                    row <= row + 1'b1;
                end
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad row-scan controller: frame scan, frame-level debounce and
// single-entry valid/ready output register with sticky overflow.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    output logic [ROW_W-1:0] row_sel,
    input  logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             overflow
);

    localparam logic [2:0] DEB = 3'(DEBOUNCE);

    state_t state_q, state_d;
    logic   tmr_clr, tmr_adv;
    logic   sample_strobe, frame_end;

    cand_t            cand, prev;
    logic [2:0]       stable_cnt, cnt_next;
    logic             rep_valid;
    logic [KEY_W-1:0] rep_code;
    logic             eval, press, release_ev;

    kp_row_timer #(.SETTLE(SETTLE)) u_timer (
        .clk           (clk),
        .nrst          (nrst),
        .clr           (tmr_clr),
        .adv           (tmr_adv),
        .row_sel       (row_sel),
        .sample_strobe (sample_strobe),
        .frame_end     (frame_end)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and row timer control; timer clears outside SCAN or when en drops.
    always_comb begin
        state_d = state_q;
        tmr_adv = (state_q == SCAN);
        tmr_clr = (state_q != SCAN) || !en;
        unique case (state_q)
            IDLE: if (en) state_d = SCAN;
            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (frame_end) begin
                    state_d = EVAL;
                end
            end
            EVAL: state_d = en ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame candidate: first pressed key in scan order, cleared between frames.
    always_ff @(posedge clk) begin
        if (!nrst || !en || state_q != SCAN) begin
            if (!nrst || !en || state_q == EVAL || state_q == IDLE) begin
                cand <= NO_KEY;
            end
        end else if (sample_strobe && !cand.valid && (|col)) begin
            cand <= '{valid: 1'b1, code: {row_sel, first_col(col)}};
        end
    end

    // Debounce evaluation of the completed frame.
    always_comb begin
        eval     = (state_q == EVAL);
        cnt_next = 3'd1;
        if (cand == prev) begin
            cnt_next = (stable_cnt >= DEB) ? DEB : stable_cnt + 3'd1;
        end
        press      = eval && cand.valid && (cnt_next == DEB)
                     && (!rep_valid || cand.code != rep_code);
        release_ev = eval && !cand.valid && (cnt_next == DEB);
    end

    // Debounce history and reported-key tracking; cleared while idle.
    always_ff @(posedge clk) begin
        if (!nrst || state_q == IDLE) begin
            prev       <= NO_KEY;
            stable_cnt <= '0;
            rep_valid  <= 1'b0;
            rep_code   <= '0;
        end else if (eval) begin
            prev       <= cand;
            stable_cnt <= cnt_next;
            if (press) begin
                rep_valid <= 1'b1;
                rep_code  <= cand.code;
            end else if (release_ev) begin
                rep_valid <= 1'b0;
            end
        end
    end

    // Output holding register: load on free slot or same-edge accept, else flag overflow.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (press) begin
            if (!key_valid || key_ready) begin
                key_code  <= cand.code;
                key_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule
